ascii_num_buffer: RTL and testbench
===================================

// Module: ascii_num_buffer
// PURPOSE
//  Upstream feeder of the matrix operation selector.
//  - Parses the UART RX byte stream (ASCII signed decimal integers, delimiter-separated).
//  - Stores each parsed integer as a 32-bit two's-complement word in a small buffer.
//  - Exposes a count/read/clear interface: the selector polls num_count, reads
//    entries by address with one-cycle latency, and clears between input phases.
// PARAMETERS
//  DEPTH    16  buffer entries; excess numbers are dropped
//  ADDR_W   4   read address width, $clog2(DEPTH)
//  COUNT_W  11  num_count width
//  DATA_W   32  stored word width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  rx_data    in   8        received ASCII byte
//  rx_valid   in   1        1-cycle strobe, rx_data valid
//  clear      in   1        1-cycle pulse: empty buffer, abort current token
//  rd_addr    in   ADDR_W   read index
//  rd_data    out  DATA_W   registered read data
//  num_count  out  COUNT_W  number of stored entries
//  parse_err  out  1        1-cycle pulse on malformed token
//  overflow   out  1        sticky: a number was dropped because the buffer was full
// BEHAVIOUR
//  Reset:
//   - rd_data=0, num_count=0, parse_err=0, overflow=0; state=IDLE; acc=0; neg=0.
//   - Buffer contents need not be reset (reads are masked by num_count).
//  Byte classes:
//   - DIG: '0'-'9'.
//   - MIN: '-'.
//   - DLM: space, ',', TAB, CR, LF.
//   - BAD: anything else.
//  FSM (advances only on rx_valid):
//   - IDLE: DIG -> acc=d, neg=0, NUM; MIN -> acc=0, neg=1, SIGN; DLM -> stay;
//     BAD -> parse_err, SKIP.
//   - SIGN: DIG -> acc=d, NUM; DLM -> parse_err, IDLE (lone '-' discarded);
//     MIN/BAD -> parse_err, SKIP.
//   - NUM: DIG -> acc=acc*10+d; DLM -> commit, IDLE; MIN/BAD -> parse_err, SKIP
//     (token discarded).
//   - SKIP: DLM -> IDLE; all other bytes ignored, no further parse_err.
//  Commit:
//   - value = neg ? -acc : acc, truncated to DATA_W.
//   - If num_count<DEPTH: buf[num_count]=value, num_count++ on the clock edge
//     that accepts the delimiter (visible the next cycle).
//   - Else: value dropped, overflow<=1, num_count unchanged.
//  End of stream: a token still in NUM with no trailing delimiter is not committed
//   until a delimiter arrives.
//  Arithmetic:
//   - acc is DATA_W unsigned; acc*10+d computed mod 2^DATA_W (see CONFIGURATION).
//   - "-0" commits 0.
//   - "-1" commits 32'hFFFF_FFFF, the selector's random-select code.
//  Read path:
//   - rd_data <= (rd_addr<num_count) ? buf[rd_addr] : 0, registered, latency 1.
//   - A commit to the same index in the same cycle returns the old (masked) value.
//  clear (highest priority):
//   - Next edge: num_count=0, overflow=0, state=IDLE, acc=0, neg=0, rd_data=0.
//   - Any rx byte in the same cycle is discarded.
//   - Clear mid-token discards the token.
//  parse_err: registered pulse, asserted the cycle after the offending byte.
// CONFIGURATION
//  NUM_BUF_SATURATE_EN:
//   - Defined: magnitude saturates instead of wrapping. Positive clamps to
//     2147483647; negative clamps to -2147483648; saturation is sticky for the token.
//   - Undefined: acc wraps mod 2^32 with no flag, e.g. "4294967297" commits 1.
// TESTING
//  1. Bytes "3 4\n" -> num_count 0->1->2; rd_addr=0 gives rd_data=3 next cycle,
//     rd_addr=1 gives 4.
//  2. "-1," -> num_count=1, rd_data=32'hFFFF_FFFF; "- 5 " -> parse_err pulse once,
//     then 5 stored at index 0.
//  3. "1a2 7 " -> parse_err pulse, only 7 stored (count=1);
//     rd_addr=3 reads 0.
//  4. 17 numbers "0 ".."16 " with DEPTH=16 -> num_count=16, overflow=1,
//     entry 15 = 15; then clear -> count 0, overflow 0.
//  5. clear coincident with delimiter of "12 " -> nothing committed, count 0;
//     rst asserted mid-token -> all outputs 0 asynchronously.
//  6. "99999999999 " -> 0x4876E7FF without the macro; 0x7FFFFFFF with
//     NUM_BUF_SATURATE_EN.

Source files
------------

// File: rtl/ascii_num_buffer.sv
// ascii_num_buffer
//   Upstream feeder of the matrix operation selector. Parses a UART RX byte
//   stream of ASCII signed decimal integers separated by delimiters. Each
//   parsed integer is stored as a DATA_W-bit two's-complement word in a small
//   buffer. The selector polls num_count and reads entries by address, with
//   one cycle of read latency.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   rx_data    in   received ASCII byte
//   rx_valid   in   one-cycle strobe, rx_data valid
//   clear      in   one-cycle pulse: empty the buffer and abort the current token
//   rd_addr    in   read index
//   rd_data    out  registered read data; 0 beyond num_count
//   num_count  out  number of stored entries
//   parse_err  out  one-cycle pulse, asserted the cycle after a malformed byte
//   overflow   out  sticky: a number was dropped because the buffer was full
//
// Build option
//   NUM_BUF_SATURATE_EN : when defined, the token magnitude saturates to the
//   signed range and no longer wraps. Positive tokens clamp to 2^(DATA_W-1)-1
//   and negative tokens clamp to -2^(DATA_W-1). Saturation stays in force for
//   the rest of the token. When undefined, the accumulator wraps mod 2^DATA_W.
module ascii_num_buffer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int COUNT_W = 11,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               clear,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [COUNT_W-1:0] num_count,
  output logic               parse_err,
  output logic               overflow
);

  typedef enum logic [1:0] {IDLE, SIGN, NUM, SKIP} state_t;
  typedef enum logic [1:0] {C_DIG, C_MIN, C_DLM, C_BAD} cls_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;
  logic                sat_q, sat_d;
  logic                err_d;
  logic                commit;
  logic [COUNT_W-1:0]  count_q;
  logic                ovf_q;
  logic [DATA_W-1:0]   rd_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  cls_t                cls;
  logic [DATA_W-1:0]   dig;
  logic [DATA_W-1:0]   acc_mac;
  logic [DATA_W-1:0]   value;
  logic                room;

  // Byte classification
  always_comb begin
    cls = C_BAD;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) cls = C_DIG;
    else if (rx_data == 8'h2D)                cls = C_MIN;
    else if (rx_data == 8'h20 || rx_data == 8'h2C || rx_data == 8'h09 ||
             rx_data == 8'h0D || rx_data == 8'h0A) cls = C_DLM;
  end

  assign dig = DATA_W'(rx_data - 8'h30);

`ifdef NUM_BUF_SATURATE_EN
  // The product is computed 4 bits wider than DATA_W, so the result can be
  // compared against the clamp limit before it is truncated. The limit
  // depends on the sign of the token: 2^(W-1) for negative tokens and
  // 2^(W-1)-1 for positive tokens.
  logic [DATA_W+3:0] acc_wide;
  logic [DATA_W-1:0] sat_lim;
  logic              sat_hit;
  assign sat_lim  = neg_q ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  assign acc_wide = ({4'b0, acc_q} * (DATA_W+4)'(10)) + {4'b0, dig};
  assign sat_hit  = sat_q || (acc_wide > {4'b0, sat_lim});
  assign acc_mac  = sat_hit ? sat_lim : acc_wide[DATA_W-1:0];
`else
  assign acc_mac  = (acc_q * DATA_W'(10)) + dig;
`endif

  // Next-state logic for the FSM. Clear has the highest priority and
  // discards any byte that arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    sat_d   = sat_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      neg_d   = 1'b0;
      sat_d   = 1'b0;
    end else if (rx_valid) begin
      unique case (state_q)
        IDLE: begin
          unique case (cls)
            C_DIG: begin acc_d = dig; neg_d = 1'b0; sat_d = 1'b0; state_d = NUM; end
            C_MIN: begin acc_d = '0;  neg_d = 1'b1; sat_d = 1'b0; state_d = SIGN; end
            C_DLM: state_d = IDLE;
            default: begin err_d = 1'b1; state_d = SKIP; end
          endcase
        end
        SIGN: begin
          unique case (cls)
            C_DIG: begin acc_d = dig; state_d = NUM; end
            C_DLM: begin err_d = 1'b1; state_d = IDLE; end  // lone '-' is discarded
            default: begin err_d = 1'b1; state_d = SKIP; end
          endcase
        end
        NUM: begin
          unique case (cls)
            C_DIG: begin
              acc_d = acc_mac;
`ifdef NUM_BUF_SATURATE_EN
              sat_d = sat_hit;
`endif
            end
            C_DLM: begin commit = 1'b1; state_d = IDLE; end
            default: begin err_d = 1'b1; state_d = SKIP; end
          endcase
        end
        default: begin  // SKIP: ignore bytes until the next delimiter
          if (cls == C_DLM) state_d = IDLE;
        end
      endcase
    end
  end

  assign value = neg_q ? (~acc_q + DATA_W'(1)) : acc_q;
  assign room  = (count_q < COUNT_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      sat_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_q      <= '0;
      parse_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      sat_q     <= sat_d;
      parse_err <= err_d;
      if (clear) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
        rd_q    <= '0;
      end else begin
        if (commit) begin
          if (room) count_q <= count_q + COUNT_W'(1);
          else      ovf_q   <= 1'b1;
        end
        // The read uses the pre-commit count and memory contents. A commit to
        // the same index in this cycle therefore returns the old, masked value.
        rd_q <= (COUNT_W'(rd_addr) < count_q) ? mem_q[rd_addr] : '0;
      end
    end
  end

  // Buffer storage is not reset. Reads are masked by num_count instead.
  always_ff @(posedge clk) begin
    if (!clear && commit && room) mem_q[count_q[ADDR_W-1:0]] <= value;
  end

  assign rd_data   = rd_q;
  assign num_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ascii_num_buffer.sv
module tb_ascii_num_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  rd_addr = 4'd0;
  logic [31:0] rd_data;
  logic [10:0] num_count;
  logic        parse_err;
  logic        overflow;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int e0;

`ifdef NUM_BUF_SATURATE_EN
  localparam logic [31:0] BIG_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] BIG_NEG = 32'h8000_0000;
  localparam logic [31:0] WRAP1   = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] BIG_POS = 32'h4876_E7FF;
  localparam logic [31:0] BIG_NEG = 32'hB789_1801;
  localparam logic [31:0] WRAP1   = 32'h0000_0001;
`endif

  ascii_num_buffer dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
    .num_count(num_count), .parse_err(parse_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Count parse_err pulses, sampling on the edge where the DUT is not updating.
  always @(negedge clk) if (parse_err) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All drive tasks start and end on a negative clock edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  initial begin
    #12;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_count", 32'(num_count), 32'd0);
    chk("rst_perr", 32'(parse_err), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Test 1: "3 4\n"
    send_str("3");
    chk("t1_cnt0", 32'(num_count), 32'd0);
    send_str(" ");
    chk("t1_cnt1", 32'(num_count), 32'd1);
    send_str("4\n");
    chk("t1_cnt2", 32'(num_count), 32'd2);
    rd(4'd0, 32'd3, "t1_rd0");
    rd(4'd1, 32'd4, "t1_rd1");

    // Test 2: "-1," is the random-select code; a lone "-" is an error.
    do_clear();
    send_str("-1,");
    chk("t2_cnt", 32'(num_count), 32'd1);
    rd(4'd0, 32'hFFFF_FFFF, "t2_neg1");
    do_clear();
    e0 = err_cnt;
    send_str("- 5 ");
    chk("t2_perr_once", 32'(err_cnt - e0), 32'd1);
    chk("t2_cnt5", 32'(num_count), 32'd1);
    rd(4'd0, 32'd5, "t2_rd5");

    // Test 3: "1a2 7 " -- the pulse appears the cycle after 'a'.
    do_clear();
    e0 = err_cnt;
    send_str("1");
    send_byte("a");
    chk("t3_perr_hi", 32'(parse_err), 32'd1);
    send_str("2 7 ");
    chk("t3_perr_once", 32'(err_cnt - e0), 32'd1);
    chk("t3_cnt", 32'(num_count), 32'd1);
    rd(4'd0, 32'd7, "t3_rd0");
    rd(4'd3, 32'd0, "t3_rd3_masked");

    // Test 4: 17 numbers into a 16-entry buffer.
    do_clear();
    for (int i = 0; i <= 16; i++) send_str($sformatf("%0d ", i));
    chk("t4_cnt", 32'(num_count), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd1);
    rd(4'd15, 32'd15, "t4_rd15");
    rd(4'd9, 32'd9, "t4_rd9");
    do_clear();
    chk("t4_clr_cnt", 32'(num_count), 32'd0);
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
    rd(4'd0, 32'd0, "t4_clr_rd0");

    // Test 5: clear coincides with the delimiter; then an async reset mid-token.
    send_str("12");
    rx_data = " "; rx_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clear = 1'b0;
    send_str(" ");
    chk("t5_clr_cnt", 32'(num_count), 32'd0);
    // Read and commit to the same index in the same cycle: old (masked) value.
    rd_addr = 4'd0;
    send_str("9");
    send_str(" ");
    chk("t5_same_cyc", rd_data, 32'd0);
    @(negedge clk);
    chk("t5_after", rd_data, 32'd9);
    for (int i = 0; i <= 16; i++) send_str("1 ");
    chk("t5_pre_ovf", 32'(overflow), 32'd1);
    send_str("5");
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_cnt", 32'(num_count), 32'd0);
    chk("t5_rst_rd", rd_data, 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    chk("t5_rst_perr", 32'(parse_err), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    send_str(" ");
    chk("t5_tok_gone", 32'(num_count), 32'd0);

    // Test 6: wrap or saturate, and "-0".
    send_str("99999999999 4294967297 -99999999999 -0 ");
    chk("t6_cnt", 32'(num_count), 32'd4);
    rd(4'd0, BIG_POS, "t6_big_pos");
    rd(4'd1, WRAP1, "t6_wrap1");
    rd(4'd2, BIG_NEG, "t6_big_neg");
    rd(4'd3, 32'd0, "t6_neg0");
    // A trailing token without a delimiter is not committed.
    send_str("42");
    chk("t6_no_dlm", 32'(num_count), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
